// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: FSM states and divider/phase clamp helpers shared by clk_en_gen and clk_en_ch
package clk_en_gen_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  // settle counter width, LOCK_W = $clog2(LOCK_CYC+1)
  function automatic int lock_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction
  // effective divider: never below 2
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return d < 32'd2 ? 32'd2 : d;
  endfunction
  // effective phase: never past the last count of the (already clamped) divider
  function automatic logic [31:0] clamp_phase(input logic [31:0] p, input logic [31:0] d);
    return p > d - 32'd1 ? d - 32'd1 : p;
  endfunction
endpackage

// File: rtl/clk_en_ch.sv
// clk_en_ch: one divider channel with shadow/active config, wrap-aligned reprogramming and gated outputs
//   refclk, rst_n : clock, async active-low reset
//   run           : counter advances this edge
//   hold          : generator idle; counter parked at phase, writes apply at once
//   resync        : realign counter to phase, pending config taken, ce suppressed
//   wr/div/phase  : config write for this channel
//   gate          : outputs enabled after this edge
//   ce, clk       : registered enable pulse and divided clock
module clk_en_ch
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             hold,
  input  logic             resync,
  input  logic             wr,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  input  logic             gate,
  output logic             ce,
  output logic             clk
);
  logic [DIV_W-1:0] sh_div, sh_ph, a_div, a_ph, cnt;
  logic [DIV_W-1:0] n_div, n_ph, w_div, w_ph, half;
  logic             pend, wrap;
  // n_* = clamped pending shadow, w_* = clamped incoming write
  always_comb begin
    n_div = DIV_W'(clamp_div(32'(sh_div)));
    n_ph  = DIV_W'(clamp_phase(32'(sh_ph), 32'(n_div)));
    w_div = DIV_W'(clamp_div(32'(div)));
    w_ph  = DIV_W'(clamp_phase(32'(phase), 32'(w_div)));
    half  = (a_div >> 1) + DIV_W'(a_div[0]);
    wrap  = cnt == a_div - DIV_W'(1);
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      sh_div <= DIV_W'(DEF_DIV);
      sh_ph  <= '0;
      a_div  <= DIV_W'(clamp_div(32'(DEF_DIV)));
      a_ph   <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
      ce     <= 1'b0;
      clk    <= 1'b0;
    end else begin
      if (wr) begin
        sh_div <= div;
        sh_ph  <= phase;
      end
      if (hold) begin
        a_div <= wr ? w_div : pend ? n_div : a_div;
        a_ph  <= wr ? w_ph : pend ? n_ph : a_ph;
        cnt   <= wr ? w_ph : pend ? n_ph : a_ph;
        pend  <= 1'b0;
      end else if (resync || (run && wrap)) begin
        // a write landing here stays pending for the next wrap
        a_div <= pend ? n_div : a_div;
        a_ph  <= pend ? n_ph : a_ph;
        cnt   <= resync ? (pend ? n_ph : a_ph) : '0;
        pend  <= wr;
      end else begin
        cnt  <= run ? cnt + DIV_W'(1) : cnt;
        pend <= pend | wr;
      end
      ce  <= gate && wrap && !resync;
      clk <= gate && cnt < half;
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel programmable clock-enable / divided-clock generator with settle-timed lock
//   refclk, rst_n           : clock, async active-low reset
//   enable, resync          : run generator / realign all channels
//   cfg_we, cfg_ch          : config write strobe and target channel
//   cfg_div, cfg_phase      : period and start offset in refclk cycles
//   cfg_ack                 : pulse the cycle after an accepted write
//   ce_o, clk_o, locked     : per-channel enable pulse, divided clock, outputs-valid flag
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 4,
  parameter int LOCK_CYC = 1024,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              resync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ack,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic              locked
);
  localparam int LOCK_W = lock_w(LOCK_CYC);
  state_t            st, st_n;
  logic [LOCK_W-1:0] sc;
  logic [NUM_CH-1:0] wr;
  logic              run, hold, gate, rs;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_comb
    st_n = !enable ? IDLE :
           st == IDLE ? SETTLE :
           st == SETTLE && sc == LOCK_W'(LOCK_CYC) ? LOCKED : st;
  // gate/run look at the next state so registered outputs switch on the same edge as locked
  always_comb begin
    locked = st == LOCKED;
    hold   = st == IDLE;
    run    = st_n != IDLE;
    gate   = st_n == LOCKED;
    rs     = resync && enable;
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      sc      <= '0;
      cfg_ack <= 1'b0;
    end else begin
      sc      <= st == SETTLE && sc != LOCK_W'(LOCK_CYC) ? sc + LOCK_W'(1) : '0;
      cfg_ack <= |wr;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // an out-of-range cfg_ch matches no channel, so it is neither applied nor acked
    assign wr[i] = cfg_we && cfg_ch == CH_W'(i);
    clk_en_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
      .refclk(refclk),
      .rst_n(rst_n),
      .run(run),
      .hold(hold),
      .resync(rs),
      .wr(wr[i]),
      .div(cfg_div),
      .phase(cfg_phase),
      .gate(gate),
      .ce(ce_o[i]),
      .clk(clk_o[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed feature tests plus randomized run against a timestamp-based reference model
module tb_clk_en_gen;
  localparam int NCH = 2;
  localparam int LK  = 8;
  localparam int DEF = 4;
  logic refclk = 1'b0, rst_n = 1'b1, enable = 1'b0, resync = 1'b0, cfg_we = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [15:0] cfg_div = '0, cfg_phase = '0;
  logic cfg_ack, locked;
  logic [NCH-1:0] ce_o, clk_o;
  int errors = 0, checks = 0;
  clk_en_gen #(.NUM_CH(NCH), .DIV_W(16), .DEF_DIV(DEF), .LOCK_CYC(LK)) dut (
    .refclk(refclk), .rst_n(rst_n), .enable(enable), .resync(resync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .cfg_ack(cfg_ack), .ce_o(ce_o), .clk_o(clk_o), .locked(locked)
  );
  always #5 refclk = ~refclk;
  // reference model: each channel's count is (edges so far - start stamp);
  // lock follows from the run length of consecutive enabled edges
  int t, rl, c;
  int md[NCH], mp[NCH], sd[NCH], sp[NCH], st[NCH];
  bit pend[NCH];
  bit idle, rse, g, w;
  logic [NCH-1:0] m_ce, m_clk;
  logic m_locked, m_ack;
  function automatic int cd(input int d);
    return d < 2 ? 2 : d;
  endfunction
  function automatic int cp(input int p, input int d);
    return p > d - 1 ? d - 1 : p;
  endfunction
  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; rl = 0; m_ce = '0; m_clk = '0; m_locked = 0; m_ack = 0;
      for (int i = 0; i < NCH; i++) begin
        md[i] = DEF; mp[i] = 0; sd[i] = DEF; sp[i] = 0; st[i] = 0; pend[i] = 0;
      end
    end else begin
      idle = rl == 0;
      rse = resync && enable;
      rl = enable ? rl + 1 : 0;
      g = rl >= LK + 2;
      m_locked = g;
      m_ack = 0;
      for (int i = 0; i < NCH; i++) begin
        c = t - st[i];
        w = cfg_we && cfg_ch == i;
        m_ce[i] = g && c == md[i] - 1 && !rse;
        m_clk[i] = g && c < (md[i] + 1) / 2;
        m_ack = m_ack | w;
        if (idle) begin
          if (w) begin md[i] = cd(int'(cfg_div)); mp[i] = cp(int'(cfg_phase), md[i]); end
          else if (pend[i]) begin md[i] = cd(sd[i]); mp[i] = cp(sp[i], md[i]); end
          st[i] = t + 1 - mp[i];
          pend[i] = 0;
        end else if (rse) begin
          if (pend[i]) begin md[i] = cd(sd[i]); mp[i] = cp(sp[i], md[i]); end
          st[i] = t + 1 - mp[i];
          pend[i] = w;
        end else if (enable) begin
          if (c == md[i] - 1) begin
            if (pend[i]) begin md[i] = cd(sd[i]); mp[i] = cp(sp[i], md[i]); end
            st[i] = t + 1;
            pend[i] = w;
          end else pend[i] = pend[i] | w;
        end else begin
          st[i] = st[i] + 1;
          pend[i] = pend[i] | w;
        end
        if (w) begin sd[i] = int'(cfg_div); sp[i] = int'(cfg_phase); end
      end
      t = t + 1;
    end
  end
  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask
  task automatic write(input int ch, input int dv, input int ph);
    cfg_we = 1; cfg_ch = 1'(ch); cfg_div = 16'(dv); cfg_phase = 16'(ph);
    tick();
    cfg_we = 0;
  endtask
  task automatic wait_ce(input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ce_o[ch]) begin n = k; break; end
    end
  endtask
  task automatic wait_lock(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (locked) begin n = k; break; end
    end
  endtask
  task automatic test_reset();
    #1 rst_n = 0;
    tick(); tick();
    checks++; if ({ce_o, clk_o, locked, cfg_ack} !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", {ce_o, clk_o, locked, cfg_ack}); end
    rst_n = 1;
    tick();
    checks++; if ({ce_o, clk_o, locked} !== 5'b0) begin errors++; $display("FAIL idle_outputs got=%b exp=0", {ce_o, clk_o, locked}); end
  endtask
  task automatic test_lock_timing();
    int n, hi;
    enable = 1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      checks++; if (locked !== (k == 9)) begin errors++; $display("FAIL lock_edge edge=%0d got=%b exp=%b", k, locked, k == 9); end
    end
    wait_ce(0, n);
    for (int j = 0; j < 3; j++) begin
      wait_ce(0, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL ce0_period got=%0d exp=4", n); end
    end
    hi = 0;
    repeat (16) begin tick(); hi += int'(clk_o[0]); end
    checks++; if (hi !== 8) begin errors++; $display("FAIL clk0_duty got=%0d exp=8", hi); end
  endtask
  task automatic test_phase();
    int n;
    enable = 0;
    tick();
    write(1, 4, 2);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL ack_pulse got=%b exp=1", cfg_ack); end
    tick();
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL ack_single got=%b exp=0", cfg_ack); end
    enable = 1;
    wait_lock(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL relock_edges got=%0d exp=10", n); end
    wait_ce(1, n);
    for (int j = 0; j < 2; j++) begin
      wait_ce(0, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL phase_lead got=%0d exp=2", n); end
      wait_ce(1, n);
      checks++; if (n !== 2) begin errors++; $display("FAIL phase_lag got=%0d exp=2", n); end
    end
  endtask
  task automatic test_reprogram();
    int n, hi;
    wait_ce(0, n);
    tick();
    write(0, 5, 0);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL reprog_ack got=%b exp=1", cfg_ack); end
    wait_ce(0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL old_period_end got=%0d exp=2", n); end
    for (int j = 0; j < 2; j++) begin
      wait_ce(0, n);
      checks++; if (n !== 5) begin errors++; $display("FAIL new_period got=%0d exp=5", n); end
    end
    hi = 0;
    repeat (10) begin tick(); hi += int'(clk_o[0]); end
    checks++; if (hi !== 6) begin errors++; $display("FAIL clk0_odd_duty got=%0d exp=6", hi); end
  endtask
  task automatic test_clamp();
    int n;
    enable = 0;
    tick();
    write(0, 0, 0);
    write(1, 1, 0);
    enable = 1;
    wait_lock(n);
    wait_ce(0, n); wait_ce(0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL clamp_div0 got=%0d exp=2", n); end
    wait_ce(1, n); wait_ce(1, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL clamp_div1 got=%0d exp=2", n); end
    enable = 0;
    tick();
    write(0, 4, 0);
    write(1, 4, 7);
    enable = 1;
    wait_lock(n);
    wait_ce(1, n); wait_ce(0, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL clamp_phase got=%0d exp=3", n); end
  endtask
  task automatic test_wrap_collision();
    int n;
    wait_ce(0, n);
    repeat (3) tick();
    write(0, 6, 0);
    checks++; if ({ce_o[0], cfg_ack} !== 2'b11) begin errors++; $display("FAIL wrap_ce_ack got=%b exp=11", {ce_o[0], cfg_ack}); end
    wait_ce(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL wrap_old_period got=%0d exp=4", n); end
    wait_ce(0, n);
    checks++; if (n !== 6) begin errors++; $display("FAIL wrap_new_period got=%0d exp=6", n); end
  endtask
  task automatic test_disable_resync();
    int n;
    wait_ce(0, n);
    tick();
    enable = 0;
    tick();
    checks++; if ({ce_o, clk_o, locked} !== 5'b0) begin errors++; $display("FAIL disable_outputs got=%b exp=0", {ce_o, clk_o, locked}); end
    write(0, 4, 0);
    write(1, 4, 1);
    enable = 1;
    wait_lock(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL reenable_lock got=%0d exp=10", n); end
    write(1, 4, 2);
    wait_ce(0, n); wait_ce(0, n);
    wait_ce(1, n); wait_ce(0, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL pre_resync_lead got=%0d exp=1", n); end
    repeat (3) tick();
    resync = 1;
    tick();
    resync = 0;
    checks++; if ({ce_o, locked} !== 3'b001) begin errors++; $display("FAIL resync_suppress got=%b exp=001", {ce_o, locked}); end
    wait_ce(1, n); wait_ce(0, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL resync_lead got=%0d exp=2", n); end
  endtask
  task automatic test_async_reset();
    int n;
    write(0, 3, 0);
    wait_ce(0, n); wait_ce(0, n); wait_ce(0, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL pre_reset_period got=%0d exp=3", n); end
    tick();
    checks++; if ({clk_o[0], locked} !== 2'b11) begin errors++; $display("FAIL pre_reset_state got=%b exp=11", {clk_o[0], locked}); end
    #2 rst_n = 0;
    #1;
    checks++; if ({ce_o, clk_o, locked, cfg_ack} !== 6'b0) begin errors++; $display("FAIL async_reset got=%b exp=0", {ce_o, clk_o, locked, cfg_ack}); end
    @(negedge refclk) rst_n = 1;
    wait_lock(n);
    checks++; if (n !== 10) begin errors++; $display("FAIL post_reset_lock got=%0d exp=10", n); end
    wait_ce(0, n); wait_ce(0, n);
    checks++; if (n !== 4) begin errors++; $display("FAIL post_reset_div got=%0d exp=4", n); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 2500; k++) begin
      enable = $urandom_range(0, 149) != 0;
      resync = $urandom_range(0, 39) == 0;
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_ch = 1'($urandom_range(0, 1));
      cfg_div = 16'($urandom_range(0, 9));
      cfg_phase = 16'($urandom_range(0, 11));
      tick();
      checks++; if ({ce_o, clk_o, locked, cfg_ack} !== {m_ce, m_clk, m_locked, m_ack}) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", k, {ce_o, clk_o, locked, cfg_ack}, {m_ce, m_clk, m_locked, m_ack}); end
    end
    resync = 0; cfg_we = 0;
  endtask
  initial begin
    test_reset();
    test_lock_timing();
    test_phase();
    test_reprogram();
    test_clamp();
    test_wrap_collision();
    test_disable_resync();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
